// File: rtl/seq_mult.sv
// ---------------------------------------------------------------------------
// seq_mult -- sequential shift-and-add unsigned multiplier.
//
// Computes a*b one multiplier bit per clock, LSB first, into an exact
// 2*WIDTH-bit accumulator. A multiply takes WIDTH RUN cycles, followed by
// a single DONE cycle in which the new result is flagged.
//
// Handshake (start/busy/done):
//   start is sampled on every rising edge. It is accepted, capturing a and b,
//   whenever the FSM is not in RUN (i.e. in IDLE or DONE); while busy=1 it
//   is ignored. done is a one-cycle pulse that coincides with the update of
//   product_full/product/overflow. Holding start high through DONE chains
//   multiplies back to back with no idle cycle in between.
//
// Parameters:
//   WIDTH        operand width in bits (2..32)
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request a multiply
//   a, b         unsigned multiplicand / multiplier (sampled on accept)
//   busy         high while the FSM is in RUN
//   done         one-cycle pulse, result valid and new
//   product_full registered full product (2*WIDTH bits)
//   product      low WIDTH bits of product_full
//   overflow     OR of the upper WIDTH bits of product_full
//   dbg_state    current FSM state (0=IDLE, 1=RUN, 2=DONE)
// ---------------------------------------------------------------------------
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product_full,
    output logic [WIDTH-1:0]     product,
    output logic                 overflow,
    output logic [1:0]           dbg_state
);

    // One spare bit so the counter never wraps for any legal WIDTH.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product_full;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_bit;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;

    // start is only honoured outside RUN.
    assign w_accept = start && (r_state != S_RUN);

    // Final RUN cycle processes multiplier bit WIDTH-1.
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Current multiplier bit, selected by a mask so the counter width does
    // not have to match the operand index width.
    assign w_bit    = |(r_b & (WIDTH'(1) << r_cnt));

    assign w_addend   = w_bit ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
    assign w_acc_next = r_acc + w_addend;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                if (start) w_next_state = S_RUN;
                else       w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a            <= '0;
            r_b            <= '0;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_product_full <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
            // Result register only moves on the edge that enters DONE, so
            // partial sums are never visible on the outputs.
            if (w_last) begin
                r_product_full <= w_acc_next;
            end
        end
    end

    assign busy         = (r_state == S_RUN);
    assign done         = (r_state == S_DONE);
    assign product_full = r_product_full;
    assign product      = r_product_full[WIDTH-1:0];
    assign overflow     = |r_product_full[2*WIDTH-1:WIDTH];
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_seq_mult.sv
// ---------------------------------------------------------------------------
// Bench for seq_mult: one WIDTH=8 and one WIDTH=3 instance. Inputs are
// driven and outputs observed on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_seq_mult;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, ov8;
  logic [15:0] pf8;
  logic [7:0]  p8;
  logic [1:0]  st8;

  // WIDTH=3 instance
  logic        start3 = 1'b0;
  logic [2:0]  a3 = '0, b3 = '0;
  logic        busy3, done3, ov3;
  logic [5:0]  pf3;
  logic [2:0]  p3;
  logic [1:0]  st3;

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product_full(pf8), .product(p8),
    .overflow(ov8), .dbg_state(st8)
  );

  seq_mult #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .product_full(pf3), .product(p3),
    .overflow(ov3), .dbg_state(st3)
  );

  // selected-instance view
  int          sel = 8;
  logic        c_done, c_busy, c_ov;
  logic [63:0] c_full, c_low;
  assign c_done = (sel == 3) ? done3 : done8;
  assign c_busy = (sel == 3) ? busy3 : busy8;
  assign c_ov   = (sel == 3) ? ov3   : ov8;
  assign c_full = (sel == 3) ? {58'd0, pf3} : {48'd0, pf8};
  assign c_low  = (sel == 3) ? {61'd0, p3}  : {56'd0, p8};

  // scoreboard
  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // driver
  task automatic drive(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv);
    if (w == 3) begin
      start3 = s; a3 = av[2:0]; b3 = bv[2:0];
    end else begin
      start8 = s; a8 = av[7:0]; b8 = bv[7:0];
    end
  endtask

  // One multiply with a one-cycle start; checks latency, busy length,
  // result fields, single-cycle done and result hold.
  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp_full, input string tag);
    int n;
    int bc;
    logic [63:0] mask;
    sel  = w;
    mask = (64'd1 << w) - 64'd1;
    @(negedge clk);
    drive(w, 1'b1, av, bv);
    @(negedge clk);
    // operands change right after capture; result must not follow them
    drive(w, 1'b0, $urandom, $urandom);
    n = 0;
    bc = 0;
    while (!c_done && n < 40) begin
      if (c_busy) bc++;
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, w);
    chk({tag, " busy_cycles"}, bc, w);
    chk({tag, " product_full"}, c_full, exp_full);
    chk({tag, " product"}, c_low, exp_full & mask);
    chk({tag, " overflow"}, {63'd0, c_ov}, {63'd0, (exp_full >> w) != 64'd0});
    chk({tag, " busy_in_done"}, {63'd0, c_busy}, 64'd0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, {63'd0, c_done}, 64'd0);
    chk({tag, " hold"}, c_full, exp_full);
  endtask

  typedef struct {
    int          w;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] full;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int n2;
    int dseen;
    logic [31:0] ra, rb;

    vecs[0] = '{3, 32'd3,   32'd2,   64'd6};
    vecs[1] = '{3, 32'd7,   32'd7,   64'd49};
    vecs[2] = '{8, 32'd255, 32'd255, 64'hFE01};
    vecs[3] = '{8, 32'd0,   32'd200, 64'd0};
    vecs[4] = '{8, 32'd12,  32'd10,  64'd120};
    vecs[5] = '{8, 32'd1,   32'd0,   64'd0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst busy8", {63'd0, busy8}, 64'd0);
    chk("rst done8", {63'd0, done8}, 64'd0);
    chk("rst pf8", {48'd0, pf8}, 64'd0);
    chk("rst p8", {56'd0, p8}, 64'd0);
    chk("rst ov8", {63'd0, ov8}, 64'd0);
    chk("rst st8", {62'd0, st8}, 64'd0);
    chk("rst pf3", {58'd0, pf3}, 64'd0);
    chk("rst busy3", {63'd0, busy3}, 64'd0);
    rst_n = 1'b1;

    // table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].full, $sformatf("vec%0d", i));
    end

    // random against a*b
    for (int i = 0; i < 20; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      exp_q.push_back({32'd0, ra} * {32'd0, rb});
      run_op(8, ra, rb, exp_q.pop_front(), $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      ra = $urandom_range(0, 7);
      rb = $urandom_range(0, 7);
      exp_q.push_back({32'd0, ra} * {32'd0, rb});
      run_op(3, ra, rb, exp_q.pop_front(), $sformatf("rnd3_%0d", i));
    end

    // start during RUN is ignored
    sel = 8;
    @(negedge clk);
    drive(8, 1'b1, 12, 10);
    @(negedge clk);
    drive(8, 1'b0, 0, 0);
    n = 0;
    while (!c_done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 2) drive(8, 1'b1, 1, 1);
      if (n == 3) drive(8, 1'b0, 0, 0);
    end
    chk("ign latency", n, 8);
    chk("ign product_full", c_full, 64'd120);
    @(negedge clk);
    chk("ign no_restart", {63'd0, c_busy}, 64'd0);
    chk("ign done_low", {63'd0, c_done}, 64'd0);

    // back to back: start held through DONE; the second accept is the edge
    // that leaves DONE, and its result arrives WIDTH edges after that
    @(negedge clk);
    drive(8, 1'b1, 3, 5);
    @(negedge clk);
    drive(8, 1'b1, 4, 4);
    n = 0;
    while (!c_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b first latency", n, 8);
    chk("b2b first product", c_full, 64'd15);
    chk("b2b busy_low_in_done", {63'd0, c_busy}, 64'd0);
    @(negedge clk);
    chk("b2b done_falls", {63'd0, c_done}, 64'd0);
    chk("b2b busy_again", {63'd0, c_busy}, 64'd1);
    drive(8, 1'b0, 0, 0);
    n2 = 1;
    while (!c_done && n2 < 40) begin
      @(negedge clk);
      n2++;
    end
    chk("b2b second spacing", n2, 9);
    chk("b2b second product", c_full, 64'd16);
    @(negedge clk);

    // reset mid-RUN
    drive(8, 1'b1, 9, 9);
    @(negedge clk);
    drive(8, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", {63'd0, busy8}, 64'd0);
    chk("abort done", {63'd0, done8}, 64'd0);
    chk("abort pf", {48'd0, pf8}, 64'd0);
    chk("abort p", {56'd0, p8}, 64'd0);
    chk("abort ov", {63'd0, ov8}, 64'd0);
    chk("abort state", {62'd0, st8}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dseen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) dseen++;
    end
    chk("abort no_done", dseen, 0);
    run_op(8, 9, 9, 64'd81, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
